ram_arbiter: RTL
================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter: CPUS, 2, number of CPUs; requesters = 2*CPUS; only CPUS=2 supported.
REQ-002 SHALL have port: CLK  in  1  clock, rising edge.
REQ-003 SHALL have port: nRST  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: iREN  in  [CPUS]  instruction read request per CPU.
REQ-005 SHALL have port: iaddr  in  [CPUS] word_t  instruction address.
REQ-006 SHALL have port: dREN, dWEN  in  [CPUS]  data read/write request per CPU.
REQ-007 SHALL have port: daddr, dstore  in  [CPUS] word_t  data address/store data.
REQ-008 SHALL have port: iwait, dwait  out  [CPUS]  stall per requester; 0 only in the completing cycle.
REQ-009 SHALL have port: iload, dload  out  [CPUS] word_t  read data returned to requester.
REQ-010 SHALL have port: ramREN, ramWEN  out  1  RAM read/write strobes.
REQ-011 SHALL have port: ramaddr, ramstore  out  word_t  RAM address/write data.
REQ-012 SHALL have port: ramload  in  word_t; ramstate  in  ramstate_t (FREE, BUSY, ACCESS, ERROR).
REQ-013 SHALL have port: gnt_valid  out  1, gnt_id  out  2  current owner (debug/coherence hook).

Function
REQ-014 Requester index SHALL be: 0=I0, 1=D0, 2=I1, 3=D1; req[k] = iREN or (dREN|dWEN) of that slot.
REQ-015 FSM SHALL have states ARB and OWN only.
REQ-016 ARB: if any req, winner = first asserted index scanning ptr+1, ptr+2, ... mod 4; register owner, go OWN; else stay ARB.
REQ-017 ARB SHALL drive no RAM strobe; all waits 1; arbitration costs exactly 1 cycle per transaction.
REQ-018 OWN SHALL route owner's address/strobe/store to RAM combinationally; non-owners: waits 1, loads 0.
REQ-019 D slot with dREN and dWEN both high SHALL be treated as write (ramWEN=1, ramREN=0).
REQ-020 OWN with ramstate==ACCESS SHALL drop owner's wait to 0 for that cycle, drive owner load = ramload on reads, set ptr = owner, go ARB.
REQ-021 OWN with ramstate BUSY, FREE or ERROR SHALL hold all waits 1 and stay OWN.
REQ-022 OWN with owner request deasserted (abort) SHALL drop strobes that cycle, go ARB, leave ptr unchanged.
REQ-023 Requests on other slots during OWN SHALL be held pending, never lost or serviced out of rotation.
REQ-024 Any continuously requesting slot SHALL be granted within 4 transactions (no starvation).
REQ-025 gnt_valid SHALL be 1 exactly in OWN; gnt_id = owner, 0 otherwise.
REQ-026 Loads SHALL be 0 for every requester not completing a read in the current cycle.

Reset
REQ-027 On nRST low: state=ARB, ptr=3 (slot 0 wins first), owner=0, immediately, independent of CLK.
REQ-028 Reset outputs: waits all 1, strobes 0, ramaddr/ramstore/loads 0, gnt_valid 0, gnt_id 0.
REQ-029 Reset mid-OWN SHALL abandon the transaction; no completion (wait=0) SHALL be signalled for it.

Structure
REQ-030 ramstate_t and word_t SHALL come from cpu_types_pkg; arb state enum and slot-index constants SHALL live in cpu_types_pkg.
REQ-031 One sub-module rr_pick (4-bit request + 2-bit ptr -> valid + 2-bit index, combinational) SHALL hold the rotation logic.

Verification
REQ-032 After reset, iREN[0]=1 iaddr=0x40, ACCESS after 2 BUSY -> ramREN=1 ramaddr=0x40, iwait[0]=0 cycle 4, iload[0]=ramload.
REQ-033 All four slots requesting continuously, RAM always ACCESS -> grant order 0,1,2,3,0 and one completion every 2 cycles.
REQ-034 dWEN[1]=1 daddr=0x80 dstore=0xDEADBEEF -> ramWEN=1 ramaddr=0x80 ramstore=0xDEADBEEF, dwait[1]=0 one cycle.
REQ-035 D0 owns, ramstate BUSY, D0 drops dREN -> next state ARB, ptr unchanged, D0 never sees dwait=0.
REQ-036 nRST pulsed during OWN with ramstate BUSY -> all waits 1, strobes 0 immediately; next grant goes to lowest requesting slot.
REQ-037 dREN[0]=dWEN[0]=1 -> write performed, ramREN=0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types for the RAM arbiter: bus word, RAM handshake state,
// arbiter FSM states and the fixed requester slot numbering.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic {
        ARB = 1'b0,
        OWN = 1'b1
    } arb_state_t;

    // Even slots are instruction ports, odd slots data ports; slot/2 is the CPU.
    localparam logic [1:0] SLOT_I0 = 2'd0;
    localparam logic [1:0] SLOT_D0 = 2'd1;
    localparam logic [1:0] SLOT_I1 = 2'd2;
    localparam logic [1:0] SLOT_D1 = 2'd3;

    localparam logic [1:0] PTR_RESET = SLOT_D1;

    function automatic logic slotIsData(input logic [1:0] slot);
        return slot[0];
    endfunction

    function automatic logic slotCpu(input logic [1:0] slot);
        return slot[1];
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// CPU-facing and RAM-facing signals of the arbiter, bundled with a slave
// modport for the arbiter and a master modport for whatever drives it.
interface ram_arbiter_if #(
    parameter int CPUS = 2
);
    import cpu_types_pkg::*;

    logic [CPUS-1:0] iREN;
    word_t           iaddr [CPUS];
    logic [CPUS-1:0] dREN;
    logic [CPUS-1:0] dWEN;
    word_t           daddr [CPUS];
    word_t           dstore[CPUS];
    logic [CPUS-1:0] iwait;
    logic [CPUS-1:0] dwait;
    word_t           iload [CPUS];
    word_t           dload [CPUS];

    logic            ramREN;
    logic            ramWEN;
    word_t           ramaddr;
    word_t           ramstore;
    word_t           ramload;
    ramstate_t       ramstate;

    logic            gnt_valid;
    logic [1:0]      gnt_id;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore,
               gnt_valid, gnt_id
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore,
               gnt_valid, gnt_id
    );

endinterface

// File: rtl/ram_arbiter_rr_pick.sv
// Round-robin picker: first asserted request scanning ptr+1, ptr+2, ... mod 4.
module rr_pick (
    input  logic [3:0] i_req,
    input  logic [1:0] i_ptr,
    output logic       o_valid,
    output logic [1:0] o_idx
);

    logic [1:0] w_cand;

    // Walk from the lowest priority (ptr itself) up, so the nearest hit overwrites.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = i_ptr;
        w_cand  = i_ptr;
        for (int k = 4; k >= 1; k--) begin
            w_cand = i_ptr + 2'(k);
            if (i_req[w_cand]) begin
                o_valid = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one RAM port between the I and D ports of two CPUs: a one-cycle
// arbitration state followed by an ownership state that forwards the winner.
module ram_arbiter
    import cpu_types_pkg::*;
#(
    parameter int CPUS = 2
) (
    input  logic          CLK,
    input  logic          nRST,
    ram_arbiter_if.slave  bus
);

    arb_state_t r_state;
    arb_state_t w_nextState;
    logic [1:0] r_ptr;
    logic [1:0] w_nextPtr;
    logic [1:0] r_owner;
    logic [1:0] w_nextOwner;

    logic [3:0] w_req;
    logic       w_pickValid;
    logic [1:0] w_pickIdx;
    logic       w_ownerCpu;
    logic       w_ownerData;
    logic       w_ownerReq;
    logic       w_ownerWrite;

    for (genvar c = 0; c < CPUS; c++) begin : g_req
        assign w_req[2*c]   = bus.iREN[c];
        assign w_req[2*c+1] = bus.dREN[c] | bus.dWEN[c];
    end

    rr_pick u_pick (
        .i_req   (w_req),
        .i_ptr   (r_ptr),
        .o_valid (w_pickValid),
        .o_idx   (w_pickIdx)
    );

    // A data slot with both strobes high is a write.
    assign w_ownerCpu   = slotCpu(r_owner);
    assign w_ownerData  = slotIsData(r_owner);
    assign w_ownerReq   = w_req[r_owner];
    assign w_ownerWrite = w_ownerData & bus.dWEN[w_ownerCpu];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= ARB;
            r_ptr   <= PTR_RESET;
            r_owner <= SLOT_I0;
        end else begin
            r_state <= w_nextState;
            r_ptr   <= w_nextPtr;
            r_owner <= w_nextOwner;
        end
    end

    always_comb begin
        w_nextState   = r_state;
        w_nextPtr     = r_ptr;
        w_nextOwner   = r_owner;
        bus.iwait     = '1;
        bus.dwait     = '1;
        for (int c = 0; c < CPUS; c++) begin
            bus.iload[c] = '0;
            bus.dload[c] = '0;
        end
        bus.ramREN    = 1'b0;
        bus.ramWEN    = 1'b0;
        bus.ramaddr   = '0;
        bus.ramstore  = '0;
        bus.gnt_valid = 1'b0;
        bus.gnt_id    = '0;

        unique case (r_state)
            ARB: begin
                if (w_pickValid) begin
                    w_nextOwner = w_pickIdx;
                    w_nextState = OWN;
                end
            end
            OWN: begin
                bus.gnt_valid = 1'b1;
                bus.gnt_id    = r_owner;
                // An owner that drops its request aborts; the pointer stays put.
                if (!w_ownerReq) begin
                    w_nextState = ARB;
                end else begin
                    bus.ramWEN   = w_ownerWrite;
                    bus.ramREN   = ~w_ownerWrite;
                    bus.ramaddr  = w_ownerData ? bus.daddr[w_ownerCpu]
                                               : bus.iaddr[w_ownerCpu];
                    bus.ramstore = w_ownerData ? bus.dstore[w_ownerCpu] : '0;
                    if (bus.ramstate == ACCESS) begin
                        if (w_ownerData) begin
                            bus.dwait[w_ownerCpu] = 1'b0;
                        end else begin
                            bus.iwait[w_ownerCpu] = 1'b0;
                        end
                        if (!w_ownerWrite) begin
                            if (w_ownerData) begin
                                bus.dload[w_ownerCpu] = bus.ramload;
                            end else begin
                                bus.iload[w_ownerCpu] = bus.ramload;
                            end
                        end
                        w_nextPtr   = r_owner;
                        w_nextState = ARB;
                    end
                end
            end
            default: w_nextState = ARB;
        endcase
    end

endmodule
